cskipa_seq_add48: RTL and testbench

CSKIPA_SEQ_ADD48 -- requirements
Module: cskipa_seq_add48

---
 rtl/cskipa_seq_add48.sv | 111 +++++++++++
 tb/tb_cskipa_seq_add48.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cskipa_seq_add48.sv
// Sequential carry-skip adder/subtractor: one SLICE_W-bit carry-skip slice per clock,
// LSB slice first, with a valid/ready handshake on both sides.
module cskipa_seq_add48 #(
    parameter int SLICE_W = 12,
    parameter int NSLICE  = 4,
    parameter int SKIP_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*NSLICE-1:0]   i_add_term1,
    input  logic [SLICE_W*NSLICE-1:0]   i_add_term2,
    input  logic                        i_sub,
    input  logic                        i_cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*NSLICE-1:0]   sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int W  = SLICE_W * NSLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [KW-1:0]       k;
    logic                carry;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [SLICE_W-1:0]  a_sl;
    logic [SLICE_W-1:0]  b_sl;
    logic [SLICE_W-1:0]  slice_sum;
    logic                slice_cout;

    // Operand registers shift right each RUN edge, so the current slice always sits in the low bits.
    assign a_sl      = a_reg[SLICE_W-1:0];
    assign b_sl      = b_reg[SLICE_W-1:0];
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    // Ripple inside each SKIP_W group; a fully propagating group passes its incoming carry straight on.
    always_comb begin : slice_adder
        logic c;
        logic grp_cin;
        logic grp_p;
        slice_sum = '0;
        c         = carry;
        grp_cin   = carry;
        grp_p     = 1'b1;
        for (int i = 0; i < SLICE_W; i++) begin
            slice_sum[i] = a_sl[i] ^ b_sl[i] ^ c;
            grp_p        = grp_p & (a_sl[i] ^ b_sl[i]);
            c            = (a_sl[i] & b_sl[i]) | ((a_sl[i] ^ b_sl[i]) & c);
            if (((i % SKIP_W) == (SKIP_W - 1)) || (i == SLICE_W - 1)) begin
                c       = grp_p ? grp_cin : c;
                grp_cin = c;
                grp_p   = 1'b1;
            end
        end
        slice_cout = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= i_add_term1;
                        b_reg <= i_sub ? ~i_add_term2 : i_add_term2;
                        carry <= i_sub ? 1'b1 : i_cin;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Result slices enter from the top; after NSLICE edges slice k lands in bits of slice k.
                    sum   <= W'({slice_sum, sum} >> SLICE_W);
                    carry <= slice_cout;
                    a_reg <= a_reg >> SLICE_W;
                    b_reg <= b_reg >> SLICE_W;
                    k     <= k + 1'b1;
                    if (k == KW'(NSLICE - 1)) begin
                        cout  <= slice_cout;
                        ovf   <= (a_reg[SLICE_W-1] == b_reg[SLICE_W-1]) &&
                                 (slice_sum[SLICE_W-1] != a_reg[SLICE_W-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cskipa_seq_add48.sv
// Testbench for cskipa_seq_add48: directed vectors with literal expectations plus an
// arithmetic reference model checked against the DUT on every falling clock edge.
module tb_cskipa_seq_add48;

    localparam int SLICE_W = 12;
    localparam int NSLICE  = 4;
    localparam int W       = SLICE_W * NSLICE;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] i_add_term1;
    logic [W-1:0] i_add_term2;
    logic         i_sub;
    logic         i_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 computing, 2 result held
    int           m_phase = 0;
    int           m_cnt   = 0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;

    cskipa_seq_add48 #(.SLICE_W(SLICE_W), .NSLICE(NSLICE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .i_add_term1(i_add_term1),
        .i_add_term2(i_add_term2),
        .i_sub      (i_sub),
        .i_cin      (i_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic sub, input logic cin);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         v;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        v    = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {v, full};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        logic [W+1:0] r;
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    r = model_result(i_add_term1, i_add_term2, i_sub, i_cin);
                    m_sum   <= r[W-1:0];
                    m_cout  <= r[W];
                    m_ovf   <= r[W+1];
                    m_cnt   <= 0;
                    m_phase <= 1;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == NSLICE) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'(m_phase == 0 && !rst));
        check("out_valid", 64'(out_valid), 64'(m_phase == 2));
        if (rst) begin
            check("rst_sum", 64'(sum), 64'h0);
            check("rst_cout", 64'(cout), 64'h0);
            check("rst_ovf", 64'(ovf), 64'h0);
        end else if (m_phase == 2) begin
            check("model_sum", 64'(sum), 64'(m_sum));
            check("model_cout", 64'(cout), 64'(m_cout));
            check("model_ovf", 64'(ovf), 64'(m_ovf));
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("accept_ready", 64'(in_ready), 64'h1);
        in_valid    = 1'b1;
        i_add_term1 = a;
        i_add_term2 = b;
        i_sub       = sub;
        i_cin       = cin;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        i_add_term1 = W'({$urandom(), $urandom()});
        i_add_term2 = W'({$urandom(), $urandom()});
        i_sub       = ~sub;
        i_cin       = ~cin;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] es, input logic ec,
                               input logic eo, input int hold);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_latency"}, 64'(waited), 64'(NSLICE));
        check({name, "_sum"}, 64'(sum), 64'(es));
        check({name, "_cout"}, 64'(cout), 64'(ec));
        check({name, "_ovf"}, 64'(ovf), 64'(eo));
        check({name, "_model"}, 64'({m_ovf, m_cout, m_sum}), 64'({eo, ec, es}));
        for (int i = 0; i < hold; i++) begin
            in_valid    = 1'b1;
            i_add_term1 = W'({$urandom(), $urandom()});
            i_add_term2 = W'({$urandom(), $urandom()});
            @(posedge clk); #1;
            check({name, "_hold_sum"}, 64'(sum), 64'(es));
            check({name, "_hold_valid"}, 64'(out_valid), 64'h1);
            check({name, "_hold_ready"}, 64'(in_ready), 64'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_release_ready"}, 64'(in_ready), 64'h1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        i_add_term1 = '0; i_add_term2 = '0; i_sub = 1'b0; i_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(in_ready), 64'h1);

        applyStimulus(48'h000000000FFF, 48'h000000000001, 1'b0, 1'b0);
        checkOutput("add_fff", 48'h000000001000, 1'b0, 1'b0, 0);
        applyStimulus(48'hFFFFFFFFFFFF, 48'h000000000001, 1'b0, 1'b0);
        checkOutput("add_wrap", 48'h000000000000, 1'b1, 1'b0, 0);
        applyStimulus(48'h000000000005, 48'h000000000007, 1'b1, 1'b0);
        checkOutput("sub_borrow", 48'hFFFFFFFFFFFE, 1'b0, 1'b0, 0);
        applyStimulus(48'h000000000007, 48'h000000000005, 1'b1, 1'b1);
        checkOutput("sub_noborrow", 48'h000000000002, 1'b1, 1'b0, 0);
        applyStimulus(48'h7FFFFFFFFFFF, 48'h000000000001, 1'b0, 1'b0);
        checkOutput("add_ovf", 48'h800000000000, 1'b0, 1'b1, 0);
        applyStimulus(48'h123456789ABC, 48'h111111111111, 1'b0, 1'b1);
        checkOutput("add_cin", 48'h23456789ABCE, 1'b0, 1'b0, 0);
        applyStimulus(48'h800000000000, 48'h000000000001, 1'b1, 1'b0);
        checkOutput("sub_ovf", 48'h7FFFFFFFFFFF, 1'b1, 1'b1, 0);
        applyStimulus(48'h000000000003, 48'h000000000004, 1'b0, 1'b0);
        checkOutput("backpressure", 48'h000000000007, 1'b0, 1'b0, 10);

        // Abort an operation two slices in, then confirm a fresh one is clean
        applyStimulus(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #2;
        check("abort_sum", 64'(sum), 64'h0);
        check("abort_flags", 64'({cout, ovf, out_valid, in_ready}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(48'h000000000001, 48'h000000000001, 1'b0, 1'b0);
        checkOutput("after_abort", 48'h000000000002, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
